// File: rtl/tree_accum_requant.sv
// Purpose: accumulate ACC_LEN adder-tree sums onto a bias, requantise with a
//          rounding arithmetic right shift, and saturate to OUT_WIDTH.
// Latency: last input beat at cycle T -> out_valid at T+2 when the output register is free.
// Backpressure: in_ready drops while a finished group waits for the output register;
//               the held output is stable until out_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abandon the partial group (never touches the output register)
//   in_valid/in_ready/in_data   signed tree sum stream
//   bias, shift       group seed and requant shift, sampled on the first beat
//   out_valid/out_ready/out_data/out_sat   saturated result stream, out_sat = clipped
//   busy              a group is in progress
module tree_accum_requant #(
    parameter int IN_WIDTH  = 20,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int ACC_LEN   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic [4:0]           shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(ACC_LEN - 1);
    localparam int SH_MAX = ACC_WIDTH - 1;

    // Saturation bounds expressed in the ACC_WIDTH+1 requant domain.
    localparam logic signed [ACC_WIDTH:0] C_OMAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] C_OMIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic {ST_ACC = 1'b0, ST_REQ = 1'b1} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [4:0]             r_shift;
    logic                   r_out_valid;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_sat;

    logic [ACC_WIDTH-1:0]        w_in_ext;
    logic [4:0]                  w_sh;
    logic [ACC_WIDTH:0]          w_rnd;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH:0]   w_r;
    logic                        w_hi;
    logic                        w_lo;
    logic [OUT_WIDTH-1:0]        w_sat_data;
    logic                        w_out_free;

    assign w_in_ext = {{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    always_comb begin
        w_sh = r_shift;
        if (int'(r_shift) > SH_MAX) begin
            w_sh = 5'(SH_MAX);
        end
    end

    // Adding half an LSB before the arithmetic shift gives round-half-up;
    // the extra bit keeps the addition from overflowing.
    assign w_rnd = (w_sh != 5'd0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << (w_sh - 5'd1)) : '0;
    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc} + w_rnd;
    assign w_r   = w_sum >>> w_sh;

    assign w_hi = (w_r > C_OMAX);
    assign w_lo = (w_r < C_OMIN);

    always_comb begin
        w_sat_data = w_r[OUT_WIDTH-1:0];
        if (w_hi) begin
            w_sat_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (w_lo) begin
            w_sat_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end
    end

    // The output register can take a new result when empty or being drained now.
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_ACC: begin
                    if (flush) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                    end else if (in_valid) begin
                        if (r_cnt == '0) begin
                            r_acc   <= bias + w_in_ext;
                            r_shift <= shift;
                        end else begin
                            r_acc <= r_acc + w_in_ext;
                        end
                        // With ACC_LEN=1 the first beat is also the last.
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_REQ;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        r_state <= ST_ACC;
                    end else if (w_out_free) begin
                        // Overrides the drain above, so a coincident handshake
                        // is replaced without a bubble.
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sat_data;
                        r_out_sat   <= w_hi || w_lo;
                        r_state     <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign busy      = (r_cnt != '0) || (r_state == ST_REQ);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_tree_accum_requant.sv
// Purpose: directed self-checking bench for tree_accum_requant with ACC_LEN=4.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven directly by the directed steps.
module tb_tree_accum_requant;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [19:0]       in_data;
    logic [31:0]       bias;
    logic [4:0]        shift;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_sat;
    logic              busy;

    int errors = 0;
    int checks = 0;

    tree_accum_requant #(
        .IN_WIDTH (20),
        .ACC_WIDTH(32),
        .OUT_WIDTH(8),
        .ACC_LEN  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bias     (bias),
        .shift    (shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Four back-to-back beats. bias/shift are only valid on the first beat;
    // later beats carry junk so a late resample would show up in the result.
    task automatic send4(input int b, input int s, input int d0, input int d1,
                         input int d2, input int d3);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 20'(d[i]);
            bias     = (i == 0) ? 32'(b) : 32'h7fff_0000;
            shift    = (i == 0) ? 5'(s) : 5'd31;
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        bias = '0; shift = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sat", out_sat, 0);

        // Basic group: (100+2)>>>2 = 25, with latency check.
        send4(0, 2, 10, 20, 30, 40);
        chk("basic_req_in_ready", in_ready, 0);
        chk("basic_req_busy", busy, 1);
        chk("basic_not_yet_valid", out_valid, 0);
        tick();
        chk("basic_out_valid", out_valid, 1);
        chk("basic_out_data", out_data, 25);
        chk("basic_out_sat", out_sat, 0);
        chk("basic_back_in_acc", in_ready, 1);
        tick();
        chk("basic_valid_pulse", out_valid, 0);

        // Negative rounding: (-8+2)>>>2 = -2.
        send4(0, 2, -7, -1, 0, 0);
        tick();
        chk("neg_out_data", out_data, -2);
        chk("neg_out_sat", out_sat, 0);

        // Bias seed with shift 0: 5+4 = 9.
        send4(5, 0, 1, 1, 1, 1);
        tick();
        chk("bias_out_data", out_data, 9);

        // Saturation both ways: +-1600 -> +-400 -> clipped.
        send4(0, 2, 400, 400, 400, 400);
        tick();
        chk("sat_pos_data", out_data, 127);
        chk("sat_pos_flag", out_sat, 1);
        send4(0, 2, -400, -400, -400, -400);
        tick();
        chk("sat_neg_data", out_data, -128);
        chk("sat_neg_flag", out_sat, 1);
        tick();

        // Backpressure: A held, B parks in REQ, one handshake swaps them.
        out_ready = 1'b0;
        send4(0, 2, 10, 20, 30, 40);
        tick();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_data", out_data, 25);
        send4(0, 2, 4, 4, 4, 4);
        tick();
        chk("bp_b_parked_in_ready", in_ready, 0);
        chk("bp_b_parked_busy", busy, 1);
        chk("bp_a_still_data", out_data, 25);
        tick();
        chk("bp_a_stable_valid", out_valid, 1);
        chk("bp_a_stable_data", out_data, 25);
        chk("bp_a_stable_sat", out_sat, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_b_no_bubble", out_valid, 1);
        chk("bp_b_data", out_data, 4);
        chk("bp_b_in_ready", in_ready, 1);
        chk("bp_b_busy", busy, 0);
        tick();
        chk("bp_b_held", out_data, 4);
        out_ready = 1'b1;
        tick();
        chk("bp_b_consumed", out_valid, 0);

        // Flush after two beats: no residue in the next group.
        in_valid = 1'b1; in_data = 20'd10; bias = '0; shift = 5'd0;
        tick();
        in_data = 20'd20;
        tick();
        in_valid = 1'b0;
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        send4(0, 0, 1, 1, 1, 1);
        tick();
        chk("flush_clean_data", out_data, 4);
        tick();

        // Flush in REQ drops the parked group but keeps the held result;
        // flush in ACC ignores that cycle's data.
        out_ready = 1'b0;
        send4(0, 2, 10, 20, 30, 40);
        tick();
        send4(0, 2, 8, 8, 8, 8);
        tick();
        chk("flushreq_parked", in_ready, 0);
        flush = 1'b1;
        tick();
        chk("flushreq_in_ready", in_ready, 1);
        chk("flushreq_busy", busy, 0);
        in_valid = 1'b1; in_data = 20'd99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flushacc_busy", busy, 0);
        chk("flush_held_valid", out_valid, 1);
        chk("flush_held_data", out_data, 25);
        out_ready = 1'b1;
        tick();
        chk("flush_held_delivered", out_valid, 0);
        send4(0, 0, 1, 1, 1, 1);
        tick();
        chk("flush_after_data", out_data, 4);
        tick();

        // Reset mid-group with a held result.
        out_ready = 1'b0;
        send4(0, 2, 400, 400, 400, 400);
        tick();
        in_valid = 1'b1; in_data = 20'd1; bias = 32'd7; shift = 5'd1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_sat", out_sat, 0);
        out_ready = 1'b1;
        send4(0, 2, 10, 20, 30, 40);
        tick();
        chk("rst_fresh_valid", out_valid, 1);
        chk("rst_fresh_data", out_data, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tree_accum_requant.md
Name: tree_accum_requant

Overview:
- Downstream consumer of the pipelined adder tree output.
- Accumulates ACC_LEN consecutive tree sums (e.g. kernel rows or input channels) into a wide accumulator, seeded with a bias.
- Requantises the total by a rounding arithmetic right shift, then saturates to OUT_WIDTH.
- Presents the result on a valid/ready output with backpressure toward the tree-side control.

Parameters:
- IN_WIDTH, 20, width of the signed tree sum input.
- ACC_WIDTH, 32, signed accumulator width; integrator sizes it ≥ IN_WIDTH+$clog2(ACC_LEN)+1 plus bias headroom.
- OUT_WIDTH, 8, signed output width after saturation.
- ACC_LEN, 9, tree sums per output group (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abandon the partial group
- in_valid  in  1  tree sum valid
- in_ready  out  1  block accepts a sum this cycle
- in_data  in  IN_WIDTH  signed tree sum
- bias  in  ACC_WIDTH  signed bias, sampled on the first beat of a group
- shift  in  5  right-shift amount, sampled on the first beat of a group
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_WIDTH  signed saturated result
- out_sat  out  1  result was clipped; qualified by out_valid
- busy  out  1  group in progress (cnt≠0 or state REQ)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: state=ACC, cnt=0, acc=0, latched bias/shift=0, out_valid=0, out_data=0, out_sat=0, busy=0. Reset mid-group or mid-REQ discards all partial work, including a held output.
- States: ACC and REQ.
- ACC:
  - in_ready=1.
  - Beat = in_valid && in_ready.
  - First beat (cnt==0): acc <= bias + sext(in_data); latch shift.
  - Later beats: acc <= acc + sext(in_data).
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation inside acc.
  - cnt increments per beat. The beat with cnt==ACC_LEN-1 sets cnt<=0 and moves to REQ.
  - ACC_LEN=1: every beat goes straight to REQ.
- REQ:
  - in_ready=0.
  - Computed in ACC_WIDTH+1 bits: r = (acc + (sh>0 ? 2^(sh-1) : 0)) >>> sh, where sh = min(shift, ACC_WIDTH-1). This is round-half-up (toward +inf on ties).
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. out_sat=1 iff clipped.
  - If out_valid==0 or out_ready==1: load out_data/out_sat, set out_valid=1, return to ACC.
  - Otherwise stay in REQ. acc is held stable.
- Output register:
  - out_valid falls on an out_valid&&out_ready cycle unless reloaded the same cycle.
  - out_data and out_sat are stable while out_valid && !out_ready.
  - Back-to-back: a REQ load coincident with a handshake replaces the result with no bubble.
- Latency: last input beat at cycle T → out_valid at T+2 if the output register is free.
- Throughput: one result per ACC_LEN+1 cycles.
- flush:
  - Priority: rst > flush > beat.
  - In ACC: cnt<=0, acc<=0, in_data that cycle is ignored.
  - In REQ: pending result is dropped, go to ACC.
  - Never affects the output register (a held result is still delivered).
- in_valid with in_ready=0 is not consumed. The upstream tree is stalled by deasserting its add_en from in_ready.

Test Plan:
- ACC_LEN=4, bias=0, shift=2, inputs 10,20,30,40 with out_ready=1 → out_data=25 ((100+2)>>>2), out_sat=0, out_valid pulses 2 cycles after the 4th beat.
- Negative rounding: bias=0, shift=2, inputs -7,-1,0,0 → out_data=-2 ((-8+2)>>>2 = floor(-1.5)), out_sat=0. Bias=5, shift=0, inputs 1,1,1,1 → out_data=9.
- Saturation: shift=2, inputs 400×4 → 127 with out_sat=1. Inputs -400×4 → -128 with out_sat=1.
- Backpressure, out_ready held 0 (shift=2, bias=0):
  - Group A (sum 100) output=25 is held.
  - Group B (inputs 4,4,4,4) parks in REQ with in_ready=0 and busy=1.
  - Raise out_ready for one cycle: A consumed; next cycle out_data=4 (B) with no loss.
  - Values are stable throughout.
- Flush after 2 beats of 10,20 → busy=0. Next group 1,1,1,1 with shift=0 → out_data=4 (no residue). Flush while a result is held → held result is still delivered.
- rst asserted mid-group (cnt=2) and while out_valid=1 → next cycle out_valid=0, in_ready=1, busy=0. A fresh group then produces the correct result.
